rggen_indirect_register_file: RTL and testbench

- Parametrised successor to the single indirect register.
- Owns a DEPTH-entry register array reached through two bus addresses: an INDEX register at OFFSET_ADDRESS and a DATA window at OFFSET_ADDRESS + BUS_WIDTH/8.
- Adds behaviour the single indirect register lacks: internal storage, auto-increment indexing with wrap, out-of-range error response, registered one-wait-state reads, and a hardware update port.
- Sits on the register bus alongside the other per-register blocks.

---
 rtl/rggen_indirect_register_file_pkg.sv | 28 ++
 rtl/rggen_indirect_register_file_entry.sv | 39 +++
 rtl/rggen_indirect_register_file.sv | 193 +++++++++++++++++++
 tb/tb_rggen_indirect_register_file.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_indirect_register_file_pkg.sv
// Bus access/status codes, FSM states and sizing helper shared by the
// indirect register file and its entry storage.
package rggen_indirect_register_file_pkg;

    localparam logic [1:0] RGGEN_READ         = 2'b10;
    localparam logic [1:0] RGGEN_WRITE        = 2'b11;
    localparam logic [1:0] RGGEN_POSTED_WRITE = 2'b01;

    localparam logic [1:0] RGGEN_OKAY   = 2'b00;
    localparam logic [1:0] RGGEN_SLVERR = 2'b10;

    typedef enum logic {
        IRF_IDLE,
        IRF_RDWAIT
    } irf_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rggen_indirect_register_file_entry.sv
// One storage word of the indirect register file: bitwise bus write,
// full-word hardware write that overrides the bus in the same cycle.
module rggen_indirect_register_file_entry #(
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_bus_write,
    input  logic [DATA_WIDTH-1:0] i_bus_strobe,
    input  logic [DATA_WIDTH-1:0] i_bus_data,
    input  logic                  i_hw_write,
    input  logic [DATA_WIDTH-1:0] i_hw_data,
    output logic [DATA_WIDTH-1:0] o_value
);

    logic [DATA_WIDTH-1:0] value_q;
    logic [DATA_WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (i_hw_write) begin
            value_d = i_hw_data;
        end else if (i_bus_write) begin
            value_d = (value_q & ~i_bus_strobe) | (i_bus_data & i_bus_strobe);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            value_q <= INITIAL_VALUE;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_value = value_q;

endmodule

// File: rtl/rggen_indirect_register_file.sv
// DEPTH-entry register array behind an INDEX/DATA address pair, with
// auto-increment, range checking, one-wait-state reads and a hardware port.
module rggen_indirect_register_file
    import rggen_indirect_register_file_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH  = 8,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
    parameter int                       BUS_WIDTH      = 32,
    parameter int                       DATA_WIDTH     = BUS_WIDTH,
    parameter int                       DEPTH          = 4,
    parameter int                       INDEX_WIDTH    = clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0]    INITIAL_VALUE  = '0
)(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_register_valid,
    input  logic [1:0]                  i_register_access,
    input  logic [ADDRESS_WIDTH-1:0]    i_register_address,
    input  logic [BUS_WIDTH-1:0]        i_register_write_data,
    input  logic [BUS_WIDTH-1:0]        i_register_strobe,
    output logic                        o_register_active,
    output logic                        o_register_ready,
    output logic [1:0]                  o_register_status,
    output logic [BUS_WIDTH-1:0]        o_register_read_data,
    output logic [DEPTH*DATA_WIDTH-1:0] o_entry_value,
    input  logic                        i_hw_write_valid,
    input  logic [INDEX_WIDTH-1:0]      i_hw_write_index,
    input  logic [DATA_WIDTH-1:0]       i_hw_write_data
);

    localparam int ADDR_LSB   = clog2(BUS_WIDTH / 8);
    localparam int WORD_WIDTH = ADDRESS_WIDTH - ADDR_LSB;
    localparam int LIMIT_WIDTH = INDEX_WIDTH + 1;

    localparam logic [WORD_WIDTH-1:0] INDEX_WORD =
        OFFSET_ADDRESS[ADDRESS_WIDTH-1:ADDR_LSB];
    localparam logic [WORD_WIDTH-1:0] DATA_WORD =
        INDEX_WORD + WORD_WIDTH'(1);
    localparam logic [LIMIT_WIDTH-1:0] DEPTH_LIMIT = LIMIT_WIDTH'(DEPTH);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = INDEX_WIDTH'(DEPTH - 1);

    logic [WORD_WIDTH-1:0]  word_address;
    logic                   index_hit;
    logic                   data_hit;
    logic                   bus_request;
    logic                   write_fire;
    logic                   read_capture;
    logic                   out_of_range;
    logic                   data_okay;
    logic [1:0]             access_status;

    irf_state_e             state_q;
    irf_state_e             state_d;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [INDEX_WIDTH-1:0] index_d;
    logic                   autoinc_q;
    logic                   autoinc_d;
    logic [BUS_WIDTH-1:0]   read_data_q;
    logic [BUS_WIDTH-1:0]   read_data_d;
    logic [1:0]             status_q;
    logic [1:0]             status_d;

    logic [BUS_WIDTH-1:0]   read_value;
    logic [DATA_WIDTH-1:0]  selected_entry;
    logic [DATA_WIDTH-1:0]  entry_value [DEPTH];
    logic [DEPTH-1:0]       bus_entry_write;
    logic [DEPTH-1:0]       hw_entry_write;
    logic                   unused_inputs;

    // Byte-lane bits of the address and bus bits beyond the fields are don't-care.
    assign unused_inputs = ^{i_register_address, i_register_access,
                             i_register_strobe, i_register_write_data};

    assign word_address      = i_register_address[ADDRESS_WIDTH-1:ADDR_LSB];
    assign index_hit         = word_address == INDEX_WORD;
    assign data_hit          = word_address == DATA_WORD;
    assign o_register_active = index_hit | data_hit;

    assign bus_request  = i_register_valid & o_register_active &
                          (state_q == IRF_IDLE);
    assign write_fire   = bus_request & i_register_access[0];
    assign read_capture = bus_request & ~i_register_access[0];

    assign out_of_range  = {1'b0, index_q} >= DEPTH_LIMIT;
    assign access_status = (data_hit & out_of_range) ? RGGEN_SLVERR : RGGEN_OKAY;
    assign data_okay     = bus_request & data_hit & ~out_of_range;

    always_comb begin
        selected_entry = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (index_q == INDEX_WIDTH'(k)) begin
                selected_entry = entry_value[k];
            end
        end
    end

    always_comb begin
        read_value = '0;
        if (index_hit) begin
            read_value[INDEX_WIDTH-1:0] = index_q;
            read_value[BUS_WIDTH-1]     = autoinc_q;
        end else if (!out_of_range) begin
            read_value[DATA_WIDTH-1:0] = selected_entry;
        end
    end

    always_comb begin
        state_d              = state_q;
        index_d              = index_q;
        autoinc_d            = autoinc_q;
        read_data_d          = read_data_q;
        status_d             = status_q;
        o_register_ready     = 1'b0;
        o_register_status    = RGGEN_OKAY;
        o_register_read_data = '0;

        unique case (state_q)
            IRF_IDLE: begin
                if (read_capture) begin
                    state_d     = IRF_RDWAIT;
                    read_data_d = read_value;
                    status_d    = access_status;
                end else if (write_fire) begin
                    o_register_ready  = 1'b1;
                    o_register_status = access_status;
                end
            end
            IRF_RDWAIT: begin
                o_register_ready     = 1'b1;
                o_register_status    = status_q;
                o_register_read_data = read_data_q;
                state_d              = IRF_IDLE;
            end
            default: begin
                state_d = IRF_IDLE;
            end
        endcase

        if (write_fire && index_hit) begin
            index_d = (index_q & ~i_register_strobe[INDEX_WIDTH-1:0]) |
                      (i_register_write_data[INDEX_WIDTH-1:0] &
                       i_register_strobe[INDEX_WIDTH-1:0]);
            if (i_register_strobe[BUS_WIDTH-1]) begin
                autoinc_d = i_register_write_data[BUS_WIDTH-1];
            end
        end

        // Reads advance on the capture edge, so the next read sees the next entry.
        if (data_okay && autoinc_q) begin
            index_d = (index_q == LAST_INDEX) ? '0 : index_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IRF_IDLE;
            index_q     <= '0;
            autoinc_q   <= 1'b0;
            read_data_q <= '0;
            status_q    <= RGGEN_OKAY;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            autoinc_q   <= autoinc_d;
            read_data_q <= read_data_d;
            status_q    <= status_d;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        assign bus_entry_write[k] = write_fire & data_hit & ~out_of_range &
                                    (index_q == INDEX_WIDTH'(k));
        assign hw_entry_write[k]  = i_hw_write_valid &
                                    (i_hw_write_index == INDEX_WIDTH'(k));

        rggen_indirect_register_file_entry #(
            .DATA_WIDTH    (DATA_WIDTH),
            .INITIAL_VALUE (INITIAL_VALUE)
        ) u_entry (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_bus_write  (bus_entry_write[k]),
            .i_bus_strobe (i_register_strobe[DATA_WIDTH-1:0]),
            .i_bus_data   (i_register_write_data[DATA_WIDTH-1:0]),
            .i_hw_write   (hw_entry_write[k]),
            .i_hw_data    (i_hw_write_data),
            .o_value      (entry_value[k])
        );

        assign o_entry_value[k*DATA_WIDTH +: DATA_WIDTH] = entry_value[k];
    end

endmodule

// File: tb/tb_rggen_indirect_register_file.sv
// Random and directed bus/hardware traffic against an array-based model
// of the indirect register file (DEPTH=5 so out-of-range indices exist).
module tb_rggen_indirect_register_file;
    import rggen_indirect_register_file_pkg::*;

    localparam int          AW    = 8;
    localparam int          BW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 5;
    localparam int          IW    = 3;
    localparam logic [31:0] INIT  = 32'hC0DE_0001;
    localparam logic [7:0]  IDX_ADDR = 8'h10;
    localparam logic [7:0]  DAT_ADDR = 8'h14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid;
    logic [1:0]        access;
    logic [AW-1:0]     address;
    logic [BW-1:0]     wdata;
    logic [BW-1:0]     strobe;
    logic              active;
    logic              ready;
    logic [1:0]        status;
    logic [BW-1:0]     rdata;
    logic [DEPTH*DW-1:0] entries;
    logic              hw_valid;
    logic [IW-1:0]     hw_index;
    logic [DW-1:0]     hw_data;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_idx;
    bit            m_ainc;

    always #5 clk = ~clk;

    rggen_indirect_register_file #(
        .ADDRESS_WIDTH  (AW),
        .OFFSET_ADDRESS (IDX_ADDR),
        .BUS_WIDTH      (BW),
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .INDEX_WIDTH    (IW),
        .INITIAL_VALUE  (INIT)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_register_valid      (valid),
        .i_register_access     (access),
        .i_register_address    (address),
        .i_register_write_data (wdata),
        .i_register_strobe     (strobe),
        .o_register_active     (active),
        .o_register_ready      (ready),
        .o_register_status     (status),
        .o_register_read_data  (rdata),
        .o_entry_value         (entries),
        .i_hw_write_valid      (hw_valid),
        .i_hw_write_index      (hw_index),
        .i_hw_write_data       (hw_data)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_idx  = 0;
        m_ainc = 1'b0;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = INIT;
    endtask

    task automatic check_entries();
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("entry%0d", k), entries[k*DW +: DW], m_mem[k]);
        end
    endtask

    task automatic bus_access(input logic [1:0] acc, input logic [7:0] addr,
                              input logic [31:0] wd, input logic [31:0] strb,
                              input bit hw_v, input int hw_i,
                              input logic [31:0] hw_d);
        bit          hi, hd, act, wr, oor;
        logic [31:0] exp_rd;
        logic [1:0]  exp_st;
        logic [2:0]  ni;
        int          lat;
        hi  = (addr >> 2) == (IDX_ADDR >> 2);
        hd  = (addr >> 2) == (DAT_ADDR >> 2);
        act = hi || hd;
        wr  = acc[0];
        oor = hd && (m_idx >= DEPTH);
        exp_st = oor ? RGGEN_SLVERR : RGGEN_OKAY;
        exp_rd = '0;
        if (hi) exp_rd = {m_ainc, 28'b0, 3'(m_idx)};
        else if (hd && !oor) exp_rd = m_mem[m_idx];

        @(negedge clk);
        valid    = 1'b1;
        access   = acc;
        address  = addr;
        wdata    = wd;
        strobe   = strb;
        hw_valid = hw_v;
        hw_index = IW'(hw_i);
        hw_data  = hw_d;
        #1;
        check("active", active, act);
        if (!act || wr) begin
            check("wr_ready", ready, act);
            if (act) check("wr_status", status, exp_st);
            @(posedge clk); #1;
        end else begin
            check("rd_wait", ready, 0);
            @(posedge clk); #1;
            hw_valid = 1'b0;
            lat = 1;
            while (!ready && lat < 8) begin
                @(posedge clk); #1;
                lat++;
            end
            check("rd_latency", lat, 1);
            check("rd_data", rdata, exp_rd);
            check("rd_status", status, exp_st);
            @(posedge clk); #1;
        end
        valid    = 1'b0;
        hw_valid = 1'b0;

        if (act && wr && hi) begin
            ni = 3'(m_idx);
            ni = (ni & ~strb[2:0]) | (wd[2:0] & strb[2:0]);
            m_idx = int'(ni);
            if (strb[31]) m_ainc = wd[31];
        end
        if (act && hd && !oor) begin
            if (wr) m_mem[m_idx] = (m_mem[m_idx] & ~strb) | (wd & strb);
            if (m_ainc) m_idx = (m_idx + 1) % DEPTH;
        end
        if (hw_v && hw_i < DEPTH) m_mem[hw_i] = hw_d;
        check_entries();
    endtask

    task automatic bwr(input logic [7:0] addr, input logic [31:0] wd);
        bus_access(RGGEN_WRITE, addr, wd, 32'hFFFF_FFFF, 1'b0, 0, 32'h0);
    endtask

    task automatic brd(input logic [7:0] addr);
        bus_access(RGGEN_READ, addr, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int          sel;
        logic [1:0]  lo;
        logic [1:0]  acc;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] strb;
        bit          hv;
        int          hi_idx;
        logic [31:0] hd;

        valid = 1'b0; access = RGGEN_READ; address = '0;
        wdata = '0; strobe = '0;
        hw_valid = 1'b0; hw_index = '0; hw_data = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_status", status, 0);
        check("rst_rdata", rdata, 0);
        check_entries();
        @(negedge clk);
        rst_n = 1'b1;

        brd(DAT_ADDR);
        brd(IDX_ADDR);

        bwr(IDX_ADDR, 32'h8000_0003);
        repeat (3) bwr(DAT_ADDR, 32'hAAAA_5555);
        check("wrap_e0", entries[0 +: DW], 32'hAAAA_5555);
        brd(IDX_ADDR);

        bwr(IDX_ADDR, 32'h0000_0006);
        brd(DAT_ADDR);
        bus_access(RGGEN_POSTED_WRITE, DAT_ADDR, 32'hDEAD_BEEF,
                   32'hFFFF_FFFF, 1'b0, 0, 32'h0);
        brd(IDX_ADDR);

        bwr(IDX_ADDR, 32'h0000_0002);
        bwr(DAT_ADDR, 32'h1234_5678);
        bus_access(RGGEN_WRITE, DAT_ADDR, 32'hFFFF_FFFF, 32'h0000_FF00,
                   1'b0, 0, 32'h0);
        check("strobe_e2", entries[2*DW +: DW], 32'h1234_FF78);

        bwr(IDX_ADDR, 32'h0000_0001);
        bus_access(RGGEN_WRITE, DAT_ADDR, 32'h1, 32'hFFFF_FFFF,
                   1'b1, 1, 32'h2);
        check("hw_wins_e1", entries[1*DW +: DW], 32'h2);

        bwr(IDX_ADDR, 32'h8000_0003);
        bus_access(RGGEN_READ, DAT_ADDR, 32'h0, 32'h0,
                   1'b1, 3, 32'h5A5A_5A5A);
        bus_access(RGGEN_WRITE, 8'h40, 32'h0, 32'hFFFF_FFFF,
                   1'b1, 7, 32'hFFFF_FFFF);

        @(negedge clk);
        valid = 1'b1; access = RGGEN_READ; address = DAT_ADDR;
        @(posedge clk); #1;
        check("pre_rst_ready", ready, 1);
        rst_n = 1'b0;
        #1;
        check("rdwait_rst_ready", ready, 0);
        model_reset();
        check_entries();
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        brd(IDX_ADDR);
        brd(DAT_ADDR);

        for (int n = 0; n < 400; n++) begin
            sel    = $urandom_range(0, 9);
            lo     = 2'($urandom_range(0, 3));
            wd     = $urandom;
            wd[2:0] = 3'($urandom_range(0, 7));
            strb   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'hFFFF_FFFF;
            hv     = ($urandom_range(0, 3) == 0);
            hi_idx = $urandom_range(0, 7);
            hd     = $urandom;
            acc    = $urandom_range(0, 1) ? RGGEN_WRITE : RGGEN_POSTED_WRITE;
            if (sel < 2) begin
                bus_access(acc, {IDX_ADDR[7:2], lo}, wd, strb, hv, hi_idx, hd);
            end else if (sel < 5) begin
                bus_access(acc, {DAT_ADDR[7:2], lo}, wd, strb, hv, hi_idx, hd);
            end else if (sel == 5) begin
                bus_access(RGGEN_READ, {IDX_ADDR[7:2], lo}, wd, strb,
                           hv, hi_idx, hd);
            end else if (sel < 9) begin
                bus_access(RGGEN_READ, {DAT_ADDR[7:2], lo}, wd, strb,
                           hv, hi_idx, hd);
            end else begin
                addr = 8'($urandom);
                if ((addr >> 2) == 8'd4 || (addr >> 2) == 8'd5) addr = 8'h80;
                bus_access($urandom_range(0, 1) ? RGGEN_READ : acc, addr,
                           wd, strb, hv, hi_idx, hd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
